// File: rtl/serial_pattern_tx_pkg.sv
// serial_pattern_tx_pkg: shared state encoding and default frame width for serial-stream blocks
package serial_pattern_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: valid/ready parallel-in, MSB-first serial-out transmitter with optional idle gap
module serial_pattern_tx
    import serial_pattern_tx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             x,
    output logic             bit_valid,
    output logic             frame_done,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept;
    logic               gap_last;

    // A new frame may be taken when idle, or on the LSB cycle when frames may abut.
    assign ready  = (state_q == ST_IDLE) || (state_q == ST_SHIFT && cnt_q == '0 && GAP == 0);
    assign accept = load && ready;

    // Next-state, shift register and bit counter.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                    sr_d    = data_in;
                    cnt_d   = CNT_W'(WIDTH - 1);
                end
            end
            ST_SHIFT: begin
                if (cnt_q != '0) begin
                    sr_d  = sr_q << 1;
                    cnt_d = cnt_q - 1'b1;
                end else if (GAP > 0) begin
                    state_d = ST_GAP;
                end else if (accept) begin
                    sr_d  = data_in;
                    cnt_d = CNT_W'(WIDTH - 1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP:  state_d = gap_last ? ST_IDLE : ST_GAP;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; the serial outputs are registered from next-state values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sr_q       <= '0;
            cnt_q      <= '0;
            x          <= 1'b0;
            bit_valid  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            x          <= (state_d == ST_SHIFT) && sr_d[WIDTH-1];
            bit_valid  <= (state_d == ST_SHIFT);
            frame_done <= (state_d == ST_SHIFT) && (cnt_d == '0);
            busy       <= (state_d != ST_IDLE);
        end
    end

    generate
        if (GAP > 0) begin : g_gap
            localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;
            logic [GW-1:0] gcnt_q, gcnt_d;
            assign gcnt_d   = (state_q == ST_SHIFT && cnt_q == '0) ? GW'(GAP - 1) :
                              (gcnt_q != '0) ? gcnt_q - 1'b1 : gcnt_q;
            assign gap_last = (gcnt_q == '0);
            // Counts the idle cycles remaining after a frame's LSB.
            always_ff @(posedge clk) begin
                if (reset) gcnt_q <= '0;
                else       gcnt_q <= gcnt_d;
            end
        end else begin : g_nogap
            assign gap_last = 1'b1;
        end
    endgenerate

endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx: directed and random checks of serial_pattern_tx against a frame-schedule model
module tb_serial_pattern_tx;

    localparam int N = 2048;

    logic       clk = 1'b0;
    logic       rst;
    logic       ld0, ld1;
    logic [7:0] dat0, dat1;
    logic       r0, x0, v0, f0, b0;
    logic       r1, x1, v1, f1, b1;

    int    tests = 0;
    int    fails = 0;
    int    cyc   = 0;
    int    bu [2];
    int    gp [2] = '{0, 3};
    bit    ex_x [2][N];
    bit    ex_v [2][N];
    bit    ex_f [2][N];
    bit    ex_b [2][N];
    string tag = "reset";

    serial_pattern_tx #(.WIDTH(8), .GAP(0)) u0 (
        .clk(clk), .reset(rst), .data_in(dat0), .load(ld0), .ready(r0),
        .x(x0), .bit_valid(v0), .frame_done(f0), .busy(b0)
    );

    serial_pattern_tx #(.WIDTH(8), .GAP(3)) u1 (
        .clk(clk), .reset(rst), .data_in(dat1), .load(ld1), .ready(r1),
        .x(x1), .bit_valid(v1), .frame_done(f1), .busy(b1)
    );

    always #5 clk = ~clk;

    function automatic bit mrdy(int d);
        return cyc > bu[d] || (gp[d] == 0 && cyc == bu[d]);
    endfunction

    task automatic upd(int d);
        logic       l = d ? ld1 : ld0;
        logic [7:0] w = d ? dat1 : dat0;
        if (rst) begin
            for (int k = cyc + 1; k <= bu[d]; k++) begin
                ex_x[d][k] = 0; ex_v[d][k] = 0; ex_f[d][k] = 0; ex_b[d][k] = 0;
            end
            bu[d] = cyc;
        end else if (l && mrdy(d)) begin
            for (int k = 0; k < 8; k++) begin
                ex_x[d][cyc+1+k] = w[7-k];
                ex_v[d][cyc+1+k] = 1;
                ex_f[d][cyc+1+k] = (k == 7);
                ex_b[d][cyc+1+k] = 1;
            end
            for (int k = 0; k < gp[d]; k++) ex_b[d][cyc+9+k] = 1;
            bu[d] = cyc + 8 + gp[d];
        end
    endtask

    task automatic check();
        for (int d = 0; d < 2; d++) begin
            logic [4:0] obs = d ? {x1, v1, f1, b1, r1} : {x0, v0, f0, b0, r0};
            logic [4:0] exp = {ex_x[d][cyc], ex_v[d][cyc], ex_f[d][cyc], ex_b[d][cyc], mrdy(d)};
            tests++;
            assert (obs === exp) else begin
                fails++;
                $error("FAIL %s dut%0d cyc %0d {x,valid,done,busy,ready}: observed %b expected %b",
                       tag, d, cyc, obs, exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        upd(0);
        upd(1);
        #1;
        cyc++;
        check();
    endtask

    initial begin
        logic [3:0] win;
        logic [7:0] w;
        bu[0] = -1;
        bu[1] = -1;
        rst = 1; ld0 = 0; ld1 = 0; dat0 = 0; dat1 = 0;
        @(posedge clk);
        #1;
        check();
        rst = 0;

        tag = "idle";
        repeat (10) tick();

        tag = "single";
        ld0 = 1; dat0 = 8'b1011_0110;
        tick();
        ld0 = 0; dat0 = 8'h00;
        repeat (10) tick();

        tag = "b2b";
        ld0 = 1; dat0 = 8'hA5;
        tick();
        dat0 = 8'h3C;
        repeat (8) tick();
        ld0 = 0;
        repeat (12) tick();

        tag = "gap";
        ld1 = 1; dat1 = 8'hFF;
        repeat (30) tick();
        ld1 = 0;
        repeat (6) tick();

        tag = "abort";
        ld0 = 1; dat0 = 8'hF0;
        tick();
        ld0 = 0;
        repeat (3) tick();
        rst = 1;
        tick();
        rst = 0;
        repeat (12) tick();

        tag = "loopback";
        w = 8'b0110_1101;
        ld0 = 1; dat0 = w;
        tick();
        ld0 = 0;
        win = 4'b0;
        for (int k = 0; k < 8; k++) begin
            logic eh;
            win = {win[2:0], x0};
            eh = (k >= 3) && (((int'(w) >> (7 - k)) & 15) == 13);
            tests++;
            assert ((win == 4'b1101) === eh) else begin
                fails++;
                $error("FAIL loopback bit %0d detect: observed %b expected %b", k, win == 4'b1101, eh);
            end
            tick();
        end
        repeat (4) tick();

        tag = "random";
        repeat (400) begin
            rst  = ($urandom_range(0, 39) == 0);
            ld0  = ($urandom_range(0, 2) != 0);
            ld1  = ($urandom_range(0, 2) != 0);
            dat0 = 8'($urandom);
            dat1 = 8'($urandom);
            tick();
        end
        rst = 0; ld0 = 0; ld1 = 0;
        repeat (20) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
